// File: rtl/clk_pkg.sv
// Shared types and defaults for the clock-source switch sequencer.
// Holds the sequencer state encoding, default timing and a width helper.
package clk_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_BLANK,
    ST_WAIT_LOCK,
    ST_SWITCH,
    ST_SETTLE
  } state_e;

  localparam int DEF_NUM_SRC       = 4;
  localparam int DEF_SEL_W         = 2;
  localparam int DEF_LOCK_FILT     = 16;
  localparam int DEF_BLANK_CYCLES  = 8;
  localparam int DEF_SETTLE_CYCLES = 64;
  localparam int DEF_LOCK_TMO      = 65535;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/lock_filt.sv
// Lock filter for one clock source: 2-FF synchroniser followed by a saturating
// counter that must see LOCK_FILT consecutive high cycles before reporting lock.
module lock_filt
  import clk_pkg::*;
#(
  parameter int LOCK_FILT = DEF_LOCK_FILT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic locked_o
);

  localparam int                CNT_W   = clog2(LOCK_FILT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LOCK_FILT);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every path assigns cnt_d because of the default first line; without it
  // the combinational block would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync_q[1])            cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: non-blocking assignments so both synchroniser stages sample the
  // pre-edge values; blocking here would collapse the two flops into one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q  <= cnt_d;
    end
  end

  assign locked_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/clksw_seq.sv
// Clock-source switch sequencer: blanks video, waits for the target PLL to lock,
// moves the glitch-free mux select, lets it settle, then releases video.
module clksw_seq
  import clk_pkg::*;
#(
  parameter int NUM_SRC       = DEF_NUM_SRC,
  parameter int SEL_W         = DEF_SEL_W,
  parameter int LOCK_FILT     = DEF_LOCK_FILT,
  parameter int BLANK_CYCLES  = DEF_BLANK_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int LOCK_TMO      = DEF_LOCK_TMO
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SEL_W-1:0]   mode_req,
  input  logic [NUM_SRC-1:0] src_locked,
  output logic [SEL_W-1:0]   clk_sel,
  output logic [SEL_W-1:0]   cur_mode,
  output logic               vid_blank,
  output logic               vid_rst,
  output logic               busy,
  output logic               err_tmo,
  output logic               err_badreq
);

  localparam int CNT_MAX_V = (SETTLE_CYCLES > BLANK_CYCLES) ? SETTLE_CYCLES : BLANK_CYCLES;
  localparam int CNT_W     = clog2(CNT_MAX_V + 1);
  localparam int TMO_W     = clog2(LOCK_TMO + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX     = TMO_W'(LOCK_TMO);
  localparam logic [SEL_W:0]   NUM_SRC_W   = (SEL_W + 1)'(NUM_SRC);

  logic [NUM_SRC-1:0]      locked_f;
  logic [2**SEL_W-1:0]     locked_pad;
  logic                    req_valid, req_bad;

  state_e                  state_q;
  logic [SEL_W-1:0]        target_q, clk_sel_q, cur_mode_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [TMO_W-1:0]        tmo_q;
  logic                    vid_blank_q, vid_rst_q, busy_q;
  logic                    err_tmo_q, err_badreq_q, bad_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_filt
    lock_filt #(.LOCK_FILT(LOCK_FILT)) u_filt (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (src_locked[i]),
      .locked_o (locked_f[i])
    );
  end

  // Pad to the full select range so any select value indexes a defined bit.
  always_comb begin
    locked_pad              = '0;
    locked_pad[NUM_SRC-1:0] = locked_f;
  end

  assign req_valid = ({1'b0, mode_req} < NUM_SRC_W);
  assign req_bad   = !req_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_WAIT_LOCK;
      target_q     <= '0;
      clk_sel_q    <= '0;
      cur_mode_q   <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      vid_blank_q  <= 1'b1;
      vid_rst_q    <= 1'b1;
      busy_q       <= 1'b1;
      err_tmo_q    <= 1'b0;
      err_badreq_q <= 1'b0;
      bad_q        <= 1'b0;
    end else begin
      err_badreq_q <= 1'b0;
      bad_q        <= 1'b0;
      case (state_q)
        ST_RUN: begin
          vid_blank_q <= 1'b0;
          vid_rst_q   <= 1'b0;
          busy_q      <= 1'b0;
          bad_q       <= req_bad;
          // Lock loss outranks a new request: retry the current source.
          if (!locked_pad[cur_mode_q] || (req_valid && mode_req != cur_mode_q)) begin
            state_q     <= ST_BLANK;
            target_q    <= locked_pad[cur_mode_q] ? mode_req : cur_mode_q;
            cnt_q       <= '0;
            vid_blank_q <= 1'b1;
            vid_rst_q   <= 1'b1;
            busy_q      <= 1'b1;
          end else if (req_bad && !bad_q) begin
            err_badreq_q <= 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            tmo_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_pad[target_q]) begin
            state_q <= ST_SWITCH;
          end else if (tmo_q == TMO_MAX) begin
            err_tmo_q <= 1'b1;
            target_q  <= '0;
            tmo_q     <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_SWITCH: begin
          clk_sel_q <= target_q;
          cnt_q     <= '0;
          state_q   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (!locked_pad[target_q]) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
          end else if (cnt_q == SETTLE_LAST) begin
            cur_mode_q <= target_q;
            state_q    <= ST_RUN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_WAIT_LOCK;
      endcase
    end
  end

  assign clk_sel    = clk_sel_q;
  assign cur_mode   = cur_mode_q;
  assign vid_blank  = vid_blank_q;
  assign vid_rst    = vid_rst_q;
  assign busy       = busy_q;
  assign err_tmo    = err_tmo_q;
  assign err_badreq = err_badreq_q;

endmodule

// File: tb/tb_clksw_seq.sv
// Self-checking bench for clksw_seq: a 4-source instance for sequencing, lock loss,
// timeout and reset, plus a 3-source instance for out-of-range requests.
module tb_clksw_seq;

  localparam int TB_FILT   = 16;
  localparam int TB_BLANK  = 8;
  localparam int TB_SETTLE = 64;
  localparam int TB_TMO    = 100;
  // Spec-level latencies, counted in clk edges from the triggering change.
  localparam int SW_LAT    = 1 + TB_BLANK + 1 + 1 + TB_SETTLE + 1;
  localparam int SEL_EDGE  = 1 + TB_BLANK + 1 + 1;
  localparam int BOOT_LAT  = 2 + TB_FILT + 1 + 1 + TB_SETTLE + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode4, mode3;
  logic [3:0] src4;
  logic [2:0] src3;
  logic [1:0] clk_sel4, cur_mode4, clk_sel3, cur_mode3;
  logic       vid_blank4, vid_rst4, busy4, err_tmo4, err_badreq4;
  logic       vid_blank3, vid_rst3, busy3, err_tmo3, err_badreq3;

  int         total = 0;
  int         bad   = 0;
  logic [1:0] model_mode;

  always #5 clk = ~clk;

  clksw_seq #(.NUM_SRC(4), .SEL_W(2), .LOCK_FILT(TB_FILT), .BLANK_CYCLES(TB_BLANK),
              .SETTLE_CYCLES(TB_SETTLE), .LOCK_TMO(TB_TMO)) dut4 (
    .clk(clk), .reset(reset), .mode_req(mode4), .src_locked(src4),
    .clk_sel(clk_sel4), .cur_mode(cur_mode4), .vid_blank(vid_blank4), .vid_rst(vid_rst4),
    .busy(busy4), .err_tmo(err_tmo4), .err_badreq(err_badreq4));

  clksw_seq #(.NUM_SRC(3), .SEL_W(2), .LOCK_FILT(TB_FILT), .BLANK_CYCLES(TB_BLANK),
              .SETTLE_CYCLES(TB_SETTLE), .LOCK_TMO(TB_TMO)) dut3 (
    .clk(clk), .reset(reset), .mode_req(mode3), .src_locked(src3),
    .clk_sel(clk_sel3), .cur_mode(cur_mode3), .vid_blank(vid_blank3), .vid_rst(vid_rst3),
    .busy(busy3), .err_tmo(err_tmo3), .err_badreq(err_badreq3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Request a pre-locked source and check the whole blank/switch/settle window.
  task automatic do_switch(input logic [1:0] nm);
    logic [1:0] old;
    old   = model_mode;
    mode4 = nm;
    for (int k = 1; k <= SW_LAT; k++) begin
      cycle();
      check("sw_blank", 32'(vid_blank4), (k < SW_LAT) ? 1 : 0);
      check("sw_sel", 32'(clk_sel4), (k >= SEL_EDGE) ? 32'(nm) : 32'(old));
      if (k == 1) begin
        check("sw_rst_rise", 32'(vid_rst4), 1);
        check("sw_cur_old", 32'(cur_mode4), 32'(old));
      end
    end
    check("sw_cur_new", 32'(cur_mode4), 32'(nm));
    check("sw_busy_done", 32'(busy4), 0);
    check("sw_rst_done", 32'(vid_rst4), 0);
    model_mode = nm;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic       saw3;
    logic [1:0] nm;

    reset = 1'b1;
    mode4 = 2'd0;
    mode3 = 2'd0;
    src4  = 4'b0001;
    src3  = 3'b001;
    model_mode = 2'd0;
    repeat (3) @(negedge clk);

    check("rst_clk_sel", 32'(clk_sel4), 0);
    check("rst_cur_mode", 32'(cur_mode4), 0);
    check("rst_vid_blank", 32'(vid_blank4), 1);
    check("rst_vid_rst", 32'(vid_rst4), 1);
    check("rst_busy", 32'(busy4), 1);
    check("rst_err_tmo", 32'(err_tmo4), 0);
    check("rst_err_badreq", 32'(err_badreq4), 0);

    // Boot: source 0 filters in, then one switch/settle pass before video runs.
    reset = 1'b0;
    for (int k = 1; k <= BOOT_LAT; k++) begin
      cycle();
      check("boot_blank", 32'(vid_blank4), (k < BOOT_LAT) ? 1 : 0);
      check("boot_sel", 32'(clk_sel4), 0);
    end
    check("boot_busy", 32'(busy4), 0);
    check("boot_err_tmo", 32'(err_tmo4), 0);
    check("boot3_busy", 32'(busy3), 0);

    src4 = 4'b1111;
    src3 = 3'b111;
    repeat (2 + TB_FILT + 2) cycle();
    check("idle_blank", 32'(vid_blank4), 0);

    do_switch(2'd2);
    for (int r = 0; r < 6; r++) begin
      do nm = 2'($urandom_range(3, 0)); while (nm == model_mode);
      do_switch(nm);
    end
    if (model_mode != 2'd1) do_switch(2'd1);

    // One-cycle lock glitch on the active source forces a full retry.
    src4[1] = 1'b0;
    cycle();
    src4[1] = 1'b1;
    n = 0;
    while (vid_blank4 !== 1'b1 && n < 10) begin cycle(); n++; end
    check("loss_blank", 32'(vid_blank4), 1);
    check("loss_cur_hold", 32'(cur_mode4), 1);
    n = 0;
    while (vid_blank4 !== 1'b0 && n < 300) begin cycle(); n++; end
    check("loss_recover", 32'(vid_blank4), 0);
    check("loss_len", 32'(n >= TB_FILT + TB_SETTLE), 1);
    check("loss_cur", 32'(cur_mode4), 1);
    check("loss_sel", 32'(clk_sel4), 1);
    check("loss_no_tmo", 32'(err_tmo4), 0);

    // Unlockable target: timeout falls back to source 0.
    src4[3] = 1'b0;
    repeat (4) cycle();
    mode4 = 2'd3;
    saw3  = 1'b0;
    n     = 0;
    while (err_tmo4 !== 1'b1 && n < 400) begin
      cycle();
      n++;
      if (clk_sel4 === 2'd3) saw3 = 1'b1;
    end
    check("tmo_set", 32'(err_tmo4), 1);
    check("tmo_len", 32'(n >= TB_BLANK + TB_TMO), 1);
    check("tmo_sel_hold", 32'(clk_sel4), 1);
    mode4 = 2'd0;
    n = 0;
    while (busy4 !== 1'b0 && n < 300) begin
      cycle();
      n++;
      if (clk_sel4 === 2'd3) saw3 = 1'b1;
    end
    check("tmo_run", 32'(busy4), 0);
    check("tmo_blank", 32'(vid_blank4), 0);
    check("tmo_sel0", 32'(clk_sel4), 0);
    check("tmo_cur0", 32'(cur_mode4), 0);
    check("tmo_sticky", 32'(err_tmo4), 1);
    check("tmo_never_sel3", 32'(saw3), 0);
    model_mode = 2'd0;

    // Out-of-range request on the 3-source instance.
    mode3 = 2'd3;
    cycle();
    check("bad_pulse", 32'(err_badreq3), 1);
    check("bad_busy", 32'(busy3), 0);
    check("bad_sel", 32'(clk_sel3), 0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("bad_once", 32'(err_badreq3), 0);
      check("bad_stay_run", 32'(busy3), 0);
    end
    mode3 = 2'd0;
    cycle();
    check("bad_clear", 32'(err_badreq3), 0);
    check("bad_cur", 32'(cur_mode3), 0);

    // Asynchronous reset in the middle of SETTLE toward source 2.
    mode4 = 2'd2;
    repeat (SEL_EDGE + 10) cycle();
    check("mid_sel2", 32'(clk_sel4), 2);
    check("mid_busy", 32'(busy4), 1);
    check("mid_blank", 32'(vid_blank4), 1);
    reset = 1'b1;
    #1;
    check("arst_sel", 32'(clk_sel4), 0);
    check("arst_blank", 32'(vid_blank4), 1);
    check("arst_rst", 32'(vid_rst4), 1);
    check("arst_busy", 32'(busy4), 1);
    check("arst_err_tmo", 32'(err_tmo4), 0);
    check("arst_cur", 32'(cur_mode4), 0);
    @(negedge clk);
    reset = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clksw_seq.md
Name: clksw_seq

Overview:
- Parametrised clock-source switch sequencer, the successor to the fixed two-source video clock select.
- Runs on the always-present system clock and arbitrates between NUM_SRC PLL/DCM-derived clock sources.
- Drives the select input of a cascaded glitch-free clock-mux tree and the video blank/reset controls.
- Adds the following, none of which the current block has:
  - per-source lock filtering;
  - ordered blank → wait-lock → switch → settle sequencing;
  - lock-timeout fallback to source 0;
  - automatic recovery on lock loss.

Parameters:
- NUM_SRC, 4, number of selectable clock sources (2..8).
- SEL_W, 2, width of the select and mode fields; must satisfy 2**SEL_W >= NUM_SRC.
- LOCK_FILT, 16, consecutive synchronised-high cycles before a source counts as locked.
- BLANK_CYCLES, 8, cycles that blank and reset are held before the select changes.
- SETTLE_CYCLES, 64, cycles after the select changes before video is released.
- LOCK_TMO, 65535, maximum WAIT_LOCK cycles before fallback.

Ports:
- clk  in  1  system clock, free-running.
- reset  in  1  asynchronous, active-high reset.
- mode_req  in  SEL_W  requested source index; level-sensitive.
- src_locked  in  NUM_SRC  raw LOCKED outputs of the sources; asynchronous to clk.
- clk_sel  out  SEL_W  select value for the clock-mux tree.
- cur_mode  out  SEL_W  source currently in use.
- vid_blank  out  1  forces video output to black.
- vid_rst  out  1  holds the video timing generator in reset.
- busy  out  1  high in every state except RUN.
- err_tmo  out  1  sticky; set when a lock timeout forces fallback.
- err_badreq  out  1  one-cycle pulse on an out-of-range request.

Behaviour:
- Reset values:
  - clk_sel=0, cur_mode=0;
  - vid_blank=1, vid_rst=1, busy=1;
  - err_tmo=0, err_badreq=0;
  - FSM=WAIT_LOCK, target=0, all counters 0.
- Lock filtering:
  - Each src_locked bit passes a 2-FF synchroniser, then a saturating counter of width clog2(LOCK_FILT+1).
  - The counter clears on any synchronised low.
  - locked_f[i]=1 when the counter equals LOCK_FILT.
  - Latency from a stable input high to locked_f: 2+LOCK_FILT cycles.
- FSM states:
  - RUN: vid_blank=0, vid_rst=0, busy=0.
    - If locked_f[cur_mode] drops → BLANK, with target=cur_mode (lock-loss retry).
    - Else, if mode_req != cur_mode and mode_req < NUM_SRC → latch target=mode_req, go to BLANK.
    - Else, if mode_req >= NUM_SRC → pulse err_badreq for 1 cycle; stay in RUN. Pulses only on the first cycle the bad value appears.
    - Lock loss takes priority over a new request in the same cycle.
  - BLANK: vid_blank=1, vid_rst=1. Count BLANK_CYCLES, then → WAIT_LOCK and clear the timeout counter.
  - WAIT_LOCK:
    - If locked_f[target] → SWITCH.
    - If the timeout counter reaches LOCK_TMO → set err_tmo, set target=0, restart WAIT_LOCK.
    - If target is already 0 when the timeout fires, stay in WAIT_LOCK indefinitely; err_tmo is set, no further change.
  - SWITCH: one cycle. clk_sel <= target registered, then → SETTLE.
  - SETTLE:
    - Count SETTLE_CYCLES. If locked_f[target] drops → BLANK.
    - On completion: cur_mode <= target, then → RUN. Outputs deassert on the first RUN cycle.
- Requests:
  - mode_req is sampled only in RUN.
  - A change during a sequence is not aborted; it is picked up on the first RUN cycle, which costs one extra sequence.
- clk_sel changes only in the SWITCH state, and always while vid_blank=1.
- Switch latency for a pre-locked target, from the mode_req change to vid_blank falling: 1+BLANK_CYCLES+1+1+SETTLE_CYCLES+1 cycles (76 with defaults).
- err_tmo clears only on reset.
- Reset mid-sequence: all state returns to reset values immediately (asynchronously); clk_sel=0.

Decomposition:
- Shared package clk_pkg holds:
  - the FSM state enum (RUN, BLANK, WAIT_LOCK, SWITCH, SETTLE);
  - default timing constants;
  - a clog2 function.
- One sub-module: lock_filt (synchroniser plus saturating counter), instantiated NUM_SRC times in a generate loop.

Test Plan:
- Reset release with src_locked=4'b0001: locked_f[0] after 18 cycles → WAIT_LOCK→SWITCH→SETTLE; vid_blank falls after the 64-cycle settle; clk_sel=0, busy=0.
- From RUN on source 0 with all sources locked, mode_req=2: vid_blank rises next cycle; clk_sel=2 only after 8 blank cycles; cur_mode=2 and vid_blank=0 exactly 76 cycles after the request.
- mode_req=3 with src_locked[3] held low, LOCK_TMO=100: err_tmo=1 after the timeout; clk_sel returns to 0; run resumes on source 0.
- In RUN on source 1, drop src_locked[1] for 1 cycle: → BLANK (vid_blank=1), retry waits for the 16-cycle re-filter, then returns to RUN with cur_mode=1.
- NUM_SRC=3, mode_req=3: single-cycle err_badreq; state stays RUN; clk_sel unchanged.
- Assert reset during SETTLE toward source 2: clk_sel=0, vid_blank=1, busy=1 immediately; no err_tmo.
